kfmmc_sector_sequencer: RTL and testbench

Sector-level front end for the MMC drive's register interface. Arbitrates two requesters by round-robin, loads the 32-bit block address and access command into the drive, then moves one 512-byte sector as a byte stream and reports completion or error. Sits between the host-side bus logic or boot loader and the drive's byte-strobe control inputs.

---
 rtl/kfmmc_sector_sequencer_if.sv | 26 ++
 rtl/kfmmc_sector_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_kfmmc_sector_sequencer.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kfmmc_sector_sequencer_if.sv
// Host-side bundle of the sector sequencer: request/grant arbitration,
// completion pulses and the read/write byte streams.
interface kfmmc_sector_sequencer_if;
  logic [1:0]  req;
  logic [1:0]  req_write;
  logic [31:0] req_lba0;
  logic [31:0] req_lba1;
  logic [1:0]  grant;
  logic        done;
  logic        error;
  logic [7:0]  rd_byte;
  logic        rd_valid;
  logic [7:0]  wr_byte;
  logic        wr_valid;
  logic        wr_ready;

  modport master (
    output req, req_write, req_lba0, req_lba1, wr_byte, wr_valid,
    input  grant, done, error, rd_byte, rd_valid, wr_ready
  );

  modport slave (
    input  req, req_write, req_lba0, req_lba1, wr_byte, wr_valid,
    output grant, done, error, rd_byte, rd_valid, wr_ready
  );
endinterface

// File: rtl/kfmmc_sector_sequencer.sv
// Sector sequencer: round-robin grant of two requesters, address/command
// load into the drive, one 512-byte sector transfer, done/error report.
// All drive strobes and host pulses are registered; outputs visible in a
// cycle belong to the state shown in that cycle.
//
// state      | meaning
// IDLE       | no owner; grant on the next request
// WAIT_READY | owner granted, waiting for drive_busy low
// ADDR       | address strobes 1..4 on consecutive cycles
// CMD        | access command strobe; counter and watchdog cleared
// XFER       | byte stream until completion, error flag or timeout
// FINISH     | done/error pulse; grant released next cycle
module kfmmc_sector_sequencer #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'hFFFFFF,
  parameter logic [7:0]  CMD_READ       = 8'h80,
  parameter logic [7:0]  CMD_WRITE      = 8'h81
) (
  input  logic                     clock,
  input  logic                     reset,
  kfmmc_sector_sequencer_if.slave  host,
  output logic [7:0]               drive_data_bus,
  output logic                     drive_write_block_address_1,
  output logic                     drive_write_block_address_2,
  output logic                     drive_write_block_address_3,
  output logic                     drive_write_block_address_4,
  output logic                     drive_write_access_command,
  output logic                     drive_write_data,
  output logic                     drive_read_data,
  input  logic [7:0]               drive_read_data_byte,
  input  logic                     drive_busy,
  input  logic                     drive_read_byte_interrupt,
  input  logic                     drive_read_completion_interrupt,
  input  logic                     drive_request_write_data_interrupt,
  input  logic                     drive_write_completion_interrupt,
  input  logic                     drive_read_interface_error,
  input  logic                     drive_read_crc_error,
  input  logic                     drive_write_interface_error
);
  typedef enum logic [2:0] {IDLE, WAIT_READY, ADDR, CMD, XFER, FINISH} state_t;

  state_t      state, state_n;
  logic [1:0]  grant_n;
  logic        prefer1, prefer1_n;
  logic [31:0] lba, lba_n;
  logic        is_write, is_write_n;
  logic [1:0]  addr_idx, addr_idx_n;
  logic [9:0]  cnt, cnt_n;
  logic [23:0] wd, wd_n, wd_inc;
  logic        comp_pend, comp_pend_n;
  logic        done_n, error_n, wr_ready_n;
  logic [7:0]  bus_n;
  logic [3:0]  addr_stb_n;
  logic        cmd_stb_n, wr_stb_n, rd_stb_n;
  logic        pick1, dir_err, byte_evt, complete_irq;
  logic [7:0]  rd_hold;

  assign wd_inc       = wd + 24'd1;
  assign dir_err      = is_write ? drive_write_interface_error
                                 : (drive_read_interface_error | drive_read_crc_error);
  assign byte_evt     = is_write ? (host.wr_valid & host.wr_ready) : drive_read_byte_interrupt;
  assign complete_irq = is_write ? drive_write_completion_interrupt : drive_read_completion_interrupt;

  // Next-state and next-output decode; byte events take priority over completion.
  always_comb begin
    state_n     = state;
    grant_n     = host.grant;
    prefer1_n   = prefer1;
    lba_n       = lba;
    is_write_n  = is_write;
    addr_idx_n  = addr_idx;
    cnt_n       = cnt;
    wd_n        = wd;
    comp_pend_n = comp_pend;
    done_n      = 1'b0;
    error_n     = 1'b0;
    wr_ready_n  = host.wr_ready;
    bus_n       = drive_data_bus;
    addr_stb_n  = 4'b0000;
    cmd_stb_n   = 1'b0;
    wr_stb_n    = 1'b0;
    rd_stb_n    = 1'b0;
    pick1       = host.req[1] & (~host.req[0] | prefer1);
    case (state)
      IDLE: begin
        wr_ready_n = 1'b0;
        if (host.req != 2'b00) begin
          grant_n    = pick1 ? 2'b10 : 2'b01;
          prefer1_n  = ~pick1;
          lba_n      = pick1 ? host.req_lba1 : host.req_lba0;
          is_write_n = pick1 ? host.req_write[1] : host.req_write[0];
          state_n    = WAIT_READY;
        end
      end
      WAIT_READY: begin
        if (!drive_busy) begin
          addr_stb_n = 4'b0001;
          bus_n      = lba[31:24];
          addr_idx_n = 2'd0;
          state_n    = ADDR;
        end
      end
      ADDR: begin
        if (addr_idx == 2'd3) begin
          cmd_stb_n   = 1'b1;
          bus_n       = is_write ? CMD_WRITE : CMD_READ;
          cnt_n       = 10'd0;
          wd_n        = 24'd0;
          comp_pend_n = 1'b0;
          state_n     = CMD;
        end else begin
          addr_idx_n = addr_idx + 2'd1;
          addr_stb_n = 4'b0010 << addr_idx;
          case (addr_idx)
            2'd0:    bus_n = lba[23:16];
            2'd1:    bus_n = lba[15:8];
            default: bus_n = lba[7:0];
          endcase
        end
      end
      CMD: begin
        wd_n    = wd_inc;
        state_n = XFER;
      end
      XFER: begin
        wd_n = wd_inc;
        if (is_write && drive_request_write_data_interrupt) wr_ready_n = 1'b1;
        if (dir_err || wd_inc == TIMEOUT_CYCLES) begin
          error_n    = 1'b1;
          wr_ready_n = 1'b0;
          state_n    = FINISH;
        end else if (byte_evt) begin
          if (cnt == 10'd512) begin
            // a 513th byte is swallowed without a strobe
            error_n    = 1'b1;
            wr_ready_n = 1'b0;
            state_n    = FINISH;
          end else begin
            cnt_n = cnt + 10'd1;
            if (is_write) begin
              wr_stb_n   = 1'b1;
              bus_n      = host.wr_byte;
              wr_ready_n = drive_request_write_data_interrupt;
            end else begin
              rd_stb_n = 1'b1;
            end
            if (complete_irq) comp_pend_n = 1'b1;
          end
        end else if (complete_irq || comp_pend) begin
          done_n     = (cnt == 10'd512);
          error_n    = (cnt != 10'd512);
          wr_ready_n = 1'b0;
          state_n    = FINISH;
        end
      end
      FINISH: begin
        grant_n    = 2'b00;
        wr_ready_n = 1'b0;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and registered-output update.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                       <= IDLE;
      prefer1                     <= 1'b0;
      lba                         <= 32'd0;
      is_write                    <= 1'b0;
      addr_idx                    <= 2'd0;
      cnt                         <= 10'd0;
      wd                          <= 24'd0;
      comp_pend                   <= 1'b0;
      host.grant                  <= 2'b00;
      host.done                   <= 1'b0;
      host.error                  <= 1'b0;
      host.wr_ready               <= 1'b0;
      drive_data_bus              <= 8'h00;
      drive_write_block_address_1 <= 1'b0;
      drive_write_block_address_2 <= 1'b0;
      drive_write_block_address_3 <= 1'b0;
      drive_write_block_address_4 <= 1'b0;
      drive_write_access_command  <= 1'b0;
      drive_write_data            <= 1'b0;
      drive_read_data             <= 1'b0;
    end else begin
      state                       <= state_n;
      prefer1                     <= prefer1_n;
      lba                         <= lba_n;
      is_write                    <= is_write_n;
      addr_idx                    <= addr_idx_n;
      cnt                         <= cnt_n;
      wd                          <= wd_n;
      comp_pend                   <= comp_pend_n;
      host.grant                  <= grant_n;
      host.done                   <= done_n;
      host.error                  <= error_n;
      host.wr_ready               <= wr_ready_n;
      drive_data_bus              <= bus_n;
      drive_write_block_address_1 <= addr_stb_n[0];
      drive_write_block_address_2 <= addr_stb_n[1];
      drive_write_block_address_3 <= addr_stb_n[2];
      drive_write_block_address_4 <= addr_stb_n[3];
      drive_write_access_command  <= cmd_stb_n;
      drive_write_data            <= wr_stb_n;
      drive_read_data             <= rd_stb_n;
    end
  end

  // Read pipeline: byte captured with the interrupt, presented one cycle after the read strobe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_hold       <= 8'h00;
      host.rd_byte  <= 8'h00;
      host.rd_valid <= 1'b0;
    end else begin
      if (rd_stb_n) rd_hold <= drive_read_data_byte;
      host.rd_valid <= drive_read_data;
      if (drive_read_data) host.rd_byte <= rd_hold;
    end
  end
endmodule

// File: tb/tb_kfmmc_sector_sequencer.sv
// Bench for kfmmc_sector_sequencer: table of sector transfers plus
// hand-written arbitration, timeout and mid-transfer reset sequences.
`timescale 1ns/1ps
module tb_kfmmc_sector_sequencer;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  kfmmc_sector_sequencer_if hif();
  logic [7:0] drive_data_bus, drive_read_data_byte;
  logic a1, a2, a3, a4, cmd_stb, wr_stb, rd_stb;
  logic drive_busy, rbi, rci, rwi, wci, rie, rce, wie;

  kfmmc_sector_sequencer #(.TIMEOUT_CYCLES(24'd1000)) dut (
    .clock(clock), .reset(reset), .host(hif.slave),
    .drive_data_bus(drive_data_bus),
    .drive_write_block_address_1(a1), .drive_write_block_address_2(a2),
    .drive_write_block_address_3(a3), .drive_write_block_address_4(a4),
    .drive_write_access_command(cmd_stb), .drive_write_data(wr_stb),
    .drive_read_data(rd_stb), .drive_read_data_byte(drive_read_data_byte),
    .drive_busy(drive_busy), .drive_read_byte_interrupt(rbi),
    .drive_read_completion_interrupt(rci), .drive_request_write_data_interrupt(rwi),
    .drive_write_completion_interrupt(wci), .drive_read_interface_error(rie),
    .drive_read_crc_error(rce), .drive_write_interface_error(wie)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {35'd0, hif.grant, hif.done, hif.error, hif.rd_byte, hif.rd_valid, hif.wr_ready,
            drive_data_bus, a1, a2, a3, a4, cmd_stb, wr_stb, rd_stb};
  endfunction

  // ---------------- monitor ----------------
  int cyc = 0, n_cmd, n_rdv, rd_bad, n_wrs, wr_bad, n_rds, n_done, n_err;
  int multi, post_abort, gchg, rst_strobes, cmd_cyc, err_cyc, a1_cyc, grant_cyc;
  logic [31:0] mon_addr;
  logic [7:0]  mon_cmd;
  bit          aborted, prev_end;
  logic [1:0]  prev_grant = 2'b00;
  logic [1:0]  grant_log[$];

  task automatic mon_clear();
    n_cmd = 0; n_rdv = 0; rd_bad = 0; n_wrs = 0; wr_bad = 0; n_rds = 0; n_done = 0;
    n_err = 0; multi = 0; post_abort = 0; gchg = 0; rst_strobes = 0; aborted = 0;
    cmd_cyc = 0; err_cyc = 0; a1_cyc = 0; grant_cyc = 0; mon_addr = 32'd0; mon_cmd = 8'd0;
    grant_log.delete();
  endtask

  always @(negedge clock) begin
    int nst;
    cyc++;
    nst = int'(a1) + int'(a2) + int'(a3) + int'(a4) + int'(cmd_stb) + int'(wr_stb) + int'(rd_stb);
    if (nst > 1) multi++;
    if (aborted && nst > 0) post_abort++;
    if (reset && nst > 0) rst_strobes++;
    if (a1) begin mon_addr[31:24] = drive_data_bus; a1_cyc = cyc; end
    if (a2) mon_addr[23:16] = drive_data_bus;
    if (a3) mon_addr[15:8]  = drive_data_bus;
    if (a4) mon_addr[7:0]   = drive_data_bus;
    if (cmd_stb) begin mon_cmd = drive_data_bus; n_cmd++; cmd_cyc = cyc; end
    if (wr_stb) begin n_wrs++; if (drive_data_bus !== 8'hA5) wr_bad++; end
    if (rd_stb) n_rds++;
    if (hif.rd_valid) begin if (hif.rd_byte !== n_rdv[7:0]) rd_bad++; n_rdv++; end
    if (hif.done) n_done++;
    if (hif.error) begin n_err++; err_cyc = cyc; aborted = 1; end
    if (prev_grant == 2'b00 && hif.grant != 2'b00) begin grant_log.push_back(hif.grant); grant_cyc = cyc; end
    if (!reset && prev_grant != 2'b00 && hif.grant != prev_grant && !prev_end) gchg++;
    prev_grant = hif.grant;
    prev_end   = hif.done | hif.error;
  end

  // ---------------- drive model ----------------
  int drv_mode = 0, drv_n = 0, drv_crc_at = -1, sent = 0, gap = 0;
  bit active = 0, comp_sent = 0;

  always @(negedge clock) begin
    rbi = 0; rci = 0; wci = 0; rwi = 0;
    if (reset || hif.done || hif.error) begin
      active = 0; rce = 0;
    end else if (cmd_stb && drv_mode != 0) begin
      active = 1; sent = 0; gap = 0; comp_sent = 0;
    end else if (active && drv_mode == 1) begin
      if (drv_crc_at >= 0 && sent == drv_crc_at) rce = 1;
      else if (sent < drv_n) begin rbi = 1; drive_read_data_byte = sent[7:0]; sent++; end
      else if (gap < 2) gap++;
      else if (!comp_sent) begin rci = 1; comp_sent = 1; end
    end else if (active && drv_mode == 2) begin
      if (wr_stb) sent++;
      if (sent < drv_n) rwi = 1;
      else if (!comp_sent) begin wci = 1; comp_sent = 1; end
    end
  end

  // ---------------- host write source ----------------
  int host_n = 0, host_sent = 0;
  always @(negedge clock) begin
    hif.wr_valid = (host_sent < host_n);
    if (hif.wr_valid && hif.wr_ready) host_sent++;
  end

  // ---------------- helpers ----------------
  task automatic wait_end(input int limit, output bit ok);
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      if (hif.done || hif.error) begin ok = 1; break; end
    end
  endtask

  task automatic wait_grant(input int limit, output bit ok);
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      if (hif.grant != 2'b00) begin ok = 1; break; end
    end
  endtask

  typedef struct {
    int          rq;
    bit          write;
    logic [31:0] lba;
    int          mode;
    int          nbytes;
    int          crc_at;
    int          busy;
    logic [1:0]  exp_grant;
    logic [7:0]  exp_cmd;
    int          exp_count;
    int          exp_done;
    int          exp_err;
  } vec_t;

  task automatic run_vec(input vec_t v, input int idx);
    bit ok;
    string p;
    p = $sformatf("v%0d_", idx);
    mon_clear();
    drv_mode = v.mode; drv_n = v.nbytes; drv_crc_at = v.crc_at;
    host_sent = 0; host_n = v.write ? v.nbytes : 0;
    hif.req_write[v.rq] = v.write;
    if (v.rq == 0) hif.req_lba0 = v.lba; else hif.req_lba1 = v.lba;
    drive_busy = (v.busy > 0);
    hif.req[v.rq] = 1'b1;
    wait_grant(20, ok);
    check({p, "grant_seen"}, ok, 1);
    check({p, "grant"}, hif.grant, v.exp_grant);
    repeat (v.busy) @(negedge clock);
    drive_busy = 1'b0;
    wait_end(3000, ok);
    check({p, "end_seen"}, ok, 1);
    hif.req[v.rq] = 1'b0;
    host_n = 0;
    repeat (6) @(negedge clock);
    check({p, "addr"}, mon_addr, v.lba);
    check({p, "addr_latency"}, a1_cyc - grant_cyc, 1 + v.busy);
    check({p, "cmd"}, mon_cmd, v.exp_cmd);
    check({p, "cmd_count"}, n_cmd, 1);
    if (v.write) begin
      check({p, "wr_strobes"}, n_wrs, v.exp_count);
      check({p, "wr_bad_bytes"}, wr_bad, 0);
    end else begin
      check({p, "rd_strobes"}, n_rds, v.exp_count);
      check({p, "rd_valids"}, n_rdv, v.exp_count);
      check({p, "rd_bad_bytes"}, rd_bad, 0);
    end
    check({p, "done"}, n_done, v.exp_done);
    check({p, "error"}, n_err, v.exp_err);
    check({p, "post_end_strobes"}, post_abort, 0);
    check({p, "multi_strobe"}, multi, 0);
    check({p, "grant_glitch"}, gchg, 0);
    check({p, "grant_released"}, hif.grant, 2'b00);
  endtask

  // ---------------- main ----------------
  vec_t vecs[6];
  logic [1:0] exp_arb[3];

  initial begin
    bit ok;
    int ends;
    vecs[0] = '{rq:0, write:0, lba:32'h12345678, mode:1, nbytes:512, crc_at:-1, busy:0,
                exp_grant:2'b01, exp_cmd:8'h80, exp_count:512, exp_done:1, exp_err:0};
    vecs[1] = '{rq:1, write:1, lba:32'h00000000, mode:2, nbytes:512, crc_at:-1, busy:0,
                exp_grant:2'b10, exp_cmd:8'h81, exp_count:512, exp_done:1, exp_err:0};
    vecs[2] = '{rq:0, write:0, lba:32'hDEADBEEF, mode:1, nbytes:512, crc_at:100, busy:0,
                exp_grant:2'b01, exp_cmd:8'h80, exp_count:100, exp_done:0, exp_err:1};
    vecs[3] = '{rq:1, write:0, lba:32'h00000001, mode:1, nbytes:512, crc_at:-1, busy:0,
                exp_grant:2'b10, exp_cmd:8'h80, exp_count:512, exp_done:1, exp_err:0};
    vecs[4] = '{rq:0, write:0, lba:32'hA0B0C0D0, mode:1, nbytes:511, crc_at:-1, busy:0,
                exp_grant:2'b01, exp_cmd:8'h80, exp_count:511, exp_done:0, exp_err:1};
    vecs[5] = '{rq:1, write:1, lba:32'h0F1E2D3C, mode:2, nbytes:512, crc_at:-1, busy:3,
                exp_grant:2'b10, exp_cmd:8'h81, exp_count:512, exp_done:1, exp_err:0};
    exp_arb[0] = 2'b01; exp_arb[1] = 2'b10; exp_arb[2] = 2'b01;

    reset = 1'b1;
    hif.req = 2'b00; hif.req_write = 2'b00; hif.req_lba0 = 32'd0; hif.req_lba1 = 32'd0;
    hif.wr_byte = 8'hA5; hif.wr_valid = 1'b0;
    drive_read_data_byte = 8'h00; drive_busy = 1'b0;
    rbi = 0; rci = 0; rwi = 0; wci = 0; rie = 0; rce = 0; wie = 0;
    mon_clear();
    repeat (3) @(negedge clock);
    check("reset_outputs", outs(), 64'd0);
    reset = 1'b0;

    // arbitration: both requesters high from reset, short sectors
    mon_clear();
    drv_mode = 1; drv_n = 8; drv_crc_at = -1;
    hif.req_lba0 = 32'h11111111; hif.req_lba1 = 32'h22222222;
    hif.req = 2'b11;
    ends = 0;
    for (int i = 0; i < 600 && ends < 3; i++) begin
      @(negedge clock);
      if (hif.done || hif.error) begin
        ends++;
        if (ends == 3) hif.req = 2'b00;
      end
    end
    hif.req = 2'b00;
    repeat (5) @(negedge clock);
    check("arb_ends", ends, 3);
    check("arb_grant_count", grant_log.size(), 3);
    for (int i = 0; i < 3 && i < grant_log.size(); i++)
      check($sformatf("arb_grant%0d", i), grant_log[i], exp_arb[i]);
    check("arb_grant_glitch", gchg, 0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // watchdog with a silent drive
    mon_clear();
    drv_mode = 0;
    hif.req_write[0] = 1'b0; hif.req_lba0 = 32'h00ABCDEF;
    hif.req[0] = 1'b1;
    wait_end(1300, ok);
    hif.req[0] = 1'b0;
    repeat (3) @(negedge clock);
    check("tmo_end_seen", ok, 1);
    check("tmo_latency", err_cyc - cmd_cyc, 1000);
    check("tmo_error", n_err, 1);
    check("tmo_done", n_done, 0);

    // reset in the middle of a read sector, owned by requester 0
    mon_clear();
    drv_mode = 1; drv_n = 512; drv_crc_at = -1;
    hif.req_lba0 = 32'h55667788;
    hif.req[0] = 1'b1;
    ok = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clock);
      if (n_rdv >= 200) begin ok = 1; break; end
    end
    check("rst_byte200_reached", ok, 1);
    #2 reset = 1'b1;
    #1 check("rst_outputs_immediate", outs(), 64'd0);
    drv_mode = 0; hif.req = 2'b00;
    repeat (3) @(negedge clock);
    check("rst_outputs_held", outs(), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_strobes_during_reset", rst_strobes, 0);
    check("rst_grant_idle", hif.grant, 2'b00);
    drv_mode = 1; drv_n = 4;
    hif.req = 2'b11;
    @(negedge clock);
    check("rst_rr_pointer", hif.grant, 2'b01);
    wait_end(200, ok);
    hif.req = 2'b00;
    check("rst_next_end_seen", ok, 1);
    repeat (4) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish within time limit");
    $fatal(1, "global timeout");
  end
endmodule
